vector_exec_unit: RTL and testbench
===================================

Name: vector_exec_unit

Overview:
- Parametrised multi-cycle vector register file plus vector ALU; the next generation of the datapath's vector path.
- Holds NVREGS vectors of LANES elements, each XLEN bits wide.
- Executes one element-wise or reduction op per start handshake, processing LPC lanes per cycle under an FSM, then pulses done and returns NZCV flags.
- Sits beside the scalar register file. Controlled by the decoder. Loaded and drained through a lane-addressed side port.

Parameters:
- XLEN, 32, element width in bits.
- LANES, 4, elements per vector. Power of two, at least 1.
- NVREGS, 16, number of vector registers. Power of two.
- LPC, 1, lanes processed per cycle. Must divide LANES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- start  in  1  request to execute; accepted only when ready=1.
- ready  out  1  unit can accept start or ld_we.
- op  in  3  ALUControl-style opcode, captured at start.
- vd, va, vb  in  $clog2(NVREGS) each  destination, source A and source B vector addresses.
- use_scalar  in  1  replace every vb lane with scalar_in.
- scalar_in  in  XLEN  broadcast operand, captured at start.
- done  out  1  one-cycle completion pulse.
- flags  out  4  {N,Z,C,V} of the last completed op.
- ld_we  in  1  write one element when ready=1.
- ld_addr, ld_lane  in  $clog2(NVREGS), $clog2(LANES)  element write address.
- ld_data  in  XLEN  element write data.
- rd_addr, rd_lane  in  $clog2(NVREGS), $clog2(LANES)  element read address.
- rd_data  out  XLEN  combinational read of the addressed element.

Behaviour:
Reset (reset=0, asynchronous):
- All vector elements are cleared to 0.
- FSM goes to IDLE; ready=1, done=0, flags=0.
- Reset during EXEC aborts the op and no later writes occur.

FSM states: IDLE, EXEC, DONE.
- IDLE:
  - start=1 latches op, vd, va, vb, use_scalar and scalar_in.
  - Clears beat counter and accumulators, then goes to EXEC.
- EXEC:
  - Runs B = LANES/LPC beats. Beat j operates on lanes j*LPC .. j*LPC+LPC-1.
  - For element-wise ops, results are written to vd at the end of each beat.
  - Sources are read in the same beat as the write, so vd==va or vd==vb is safe.
  - After beat B-1, goes to DONE.
- DONE:
  - done=1 and ready=1 for exactly one cycle; flags are updated on entry.
  - start=1 here is accepted (back-to-back ops): next state EXEC. Otherwise next state IDLE.
- Latency: start sampled at edge k, lanes written at edges k+1..k+B, done high during the cycle following edge k+B.

ready and start rules:
- ready=1 in IDLE and DONE, 0 in EXEC.
- start or ld_we while ready=0 is ignored. No queuing, no error.

Opcodes (modulo 2^XLEN, per lane, b = vb lane or scalar_in):
- 000 ADD a+b.
- 001 SUB a-b.
- 010 AND.
- 011 ORR.
- 100 XOR.
- 101 MINU (unsigned minimum).
- 110 MAXU (unsigned maximum).
- 111 RSUM:
  - Sums all va lanes, modulo 2^XLEN; b is ignored.
  - Nothing is written until the last beat edge.
  - At the last beat edge, the sum is written to vd lane 0 and every other lane of vd is written with 0.

Flags, over all result lanes:
- N = OR of result MSBs.
- Z = 1 iff every result lane is 0.
- C = OR of per-lane carry-out; for SUB, carry means no borrow.
- V = OR of per-lane signed overflow.
- C and V are 0 for ops other than ADD/SUB.
- For RSUM, N/Z use the full written vector; C/V are 0.
- flags hold their value until the next DONE.

Side port and read port:
- ld_we write with ready=1 takes effect at the clock edge.
- ld_we and start in the same IDLE cycle are both honoured. The ld write lands first and is visible to the op.
- rd_data is combinational and valid in any state, including mid-EXEC, where it shows partially written vd.

Test Plan:
1. XLEN=32, LANES=4, LPC=1. Load va=v1={1,2,3,0xFFFFFFFF}, vb=v2={1,1,1,1}; start ADD vd=v3 -> done exactly 4 cycles after start edge; v3={2,3,4,0}; flags N=0, Z=0, C=1, V=0.
2. SUB v1-v1 into v1 (vd==va) -> v1={0,0,0,0}; flags Z=1, C=1, N=0.
3. use_scalar=1, scalar_in=0x80000000, ORR va=v2 -> every lane 0x80000001; N=1. Raising start during EXEC has no effect.
4. RSUM va={5,6,7,8} into v4 (v4 preloaded nonzero) -> v4={26,0,0,0}; Z=0. Back-to-back start asserted in the DONE cycle -> second op begins with no idle gap.
5. LPC=2, LANES=8: MAXU over 8 lanes -> done 4 cycles after start. Assert reset=0 at beat 2 -> ready=1, done=0, flags=0, all rd_data reads 0.
6. ld_we with ready=0 (mid-EXEC) -> target element unchanged. ld_we with start in the same IDLE cycle on va lane 0 -> op uses the new value.

Source files
------------

// File: rtl/vector_exec_unit.sv
// Vector register file plus lane-serial vector ALU: one element-wise or reduction op
// per start, LPC lanes per beat, with NZCV flags reported at completion.
`timescale 1ns/1ps
module vector_exec_unit #(
    parameter int XLEN   = 32,
    parameter int LANES  = 4,
    parameter int NVREGS = 16,
    parameter int LPC    = 1,
    localparam int AW    = (NVREGS > 1) ? $clog2(NVREGS) : 1,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            ready,
    input  logic [2:0]      op,
    input  logic [AW-1:0]   vd,
    input  logic [AW-1:0]   va,
    input  logic [AW-1:0]   vb,
    input  logic            use_scalar,
    input  logic [XLEN-1:0] scalar_in,
    output logic            done,
    output logic [3:0]      flags,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [LW-1:0]   ld_lane,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW-1:0]   rd_addr,
    input  logic [LW-1:0]   rd_lane,
    output logic [XLEN-1:0] rd_data
);
    localparam int BEATS = LANES / LPC;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0] OP_RSUM = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] vrf [NVREGS][LANES];

    logic [2:0]      op_q;
    logic [AW-1:0]   vd_q, va_q, vb_q;
    logic            use_scalar_q;
    logic [XLEN-1:0] scalar_q;
    logic [BW-1:0]   beat_q;
    logic            n_acc, nz_acc, c_acc, v_acc;
    logic [XLEN-1:0] sum_acc;

    logic [LW-1:0]   lane_idx [LPC];
    logic [XLEN-1:0] a_l [LPC];
    logic [XLEN-1:0] b_l [LPC];
    logic [XLEN:0]   wide [LPC];
    logic [XLEN-1:0] res [LPC];
    logic            beat_n, beat_nz, beat_c, beat_v, last_beat;
    logic [XLEN-1:0] beat_sum, rsum_total;
    logic [3:0]      final_flags;

    assign rd_data = vrf[rd_addr][rd_lane];

    // Per-beat lane results; flags are folded into the running accumulators.
    always_comb begin
        beat_n   = 1'b0;
        beat_nz  = 1'b0;
        beat_c   = 1'b0;
        beat_v   = 1'b0;
        beat_sum = '0;
        for (int unsigned l = 0; l < LPC; l++) begin
            lane_idx[l] = LW'(32'(beat_q) * LPC + l);
            a_l[l]      = vrf[va_q][lane_idx[l]];
            b_l[l]      = use_scalar_q ? scalar_q : vrf[vb_q][lane_idx[l]];
            wide[l]     = '0;
            res[l]      = '0;
            case (op_q)
                3'b000: begin
                    wide[l] = {1'b0, a_l[l]} + {1'b0, b_l[l]};
                    res[l]  = wide[l][XLEN-1:0];
                    beat_c  = beat_c | wide[l][XLEN];
                    beat_v  = beat_v | ((a_l[l][XLEN-1] == b_l[l][XLEN-1]) &&
                                        (res[l][XLEN-1] != a_l[l][XLEN-1]));
                end
                3'b001: begin
                    wide[l] = {1'b0, a_l[l]} + {1'b0, ~b_l[l]} + (XLEN+1)'(1);
                    res[l]  = wide[l][XLEN-1:0];
                    beat_c  = beat_c | wide[l][XLEN];
                    beat_v  = beat_v | ((a_l[l][XLEN-1] != b_l[l][XLEN-1]) &&
                                        (res[l][XLEN-1] != a_l[l][XLEN-1]));
                end
                3'b010: res[l] = a_l[l] & b_l[l];
                3'b011: res[l] = a_l[l] | b_l[l];
                3'b100: res[l] = a_l[l] ^ b_l[l];
                3'b101: res[l] = (a_l[l] < b_l[l]) ? a_l[l] : b_l[l];
                3'b110: res[l] = (a_l[l] > b_l[l]) ? a_l[l] : b_l[l];
                default: begin
                    res[l]   = a_l[l];
                    beat_sum = beat_sum + a_l[l];
                end
            endcase
            beat_n  = beat_n | res[l][XLEN-1];
            beat_nz = beat_nz | (|res[l]);
        end
        rsum_total = sum_acc + beat_sum;
        last_beat  = (beat_q == BW'(BEATS - 1));
        if (op_q == OP_RSUM)
            final_flags = {rsum_total[XLEN-1], rsum_total == '0, 2'b00};
        else
            final_flags = {n_acc | beat_n, ~(nz_acc | beat_nz), c_acc | beat_c, v_acc | beat_v};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXEC;
            EXEC:    if (last_beat) state_d = DONE;
            DONE:    state_d = start ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q != EXEC);
        done  = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NVREGS; r++)
                for (int unsigned l = 0; l < LANES; l++)
                    vrf[r][l] <= '0;
            op_q         <= '0;
            vd_q         <= '0;
            va_q         <= '0;
            vb_q         <= '0;
            use_scalar_q <= 1'b0;
            scalar_q     <= '0;
            beat_q       <= '0;
            n_acc        <= 1'b0;
            nz_acc       <= 1'b0;
            c_acc        <= 1'b0;
            v_acc        <= 1'b0;
            sum_acc      <= '0;
            flags        <= '0;
        end else begin
            if (ld_we && ready) vrf[ld_addr][ld_lane] <= ld_data;
            if (start && ready) begin
                op_q         <= op;
                vd_q         <= vd;
                va_q         <= va;
                vb_q         <= vb;
                use_scalar_q <= use_scalar;
                scalar_q     <= scalar_in;
                beat_q       <= '0;
                n_acc        <= 1'b0;
                nz_acc       <= 1'b0;
                c_acc        <= 1'b0;
                v_acc        <= 1'b0;
                sum_acc      <= '0;
            end
            if (state_q == EXEC) begin
                beat_q  <= beat_q + BW'(1);
                n_acc   <= n_acc | beat_n;
                nz_acc  <= nz_acc | beat_nz;
                c_acc   <= c_acc | beat_c;
                v_acc   <= v_acc | beat_v;
                sum_acc <= rsum_total;
                if (op_q != OP_RSUM) begin
                    for (int unsigned l = 0; l < LPC; l++)
                        vrf[vd_q][lane_idx[l]] <= res[l];
                end else if (last_beat) begin
                    for (int unsigned j = 0; j < LANES; j++)
                        vrf[vd_q][j] <= (j == 0) ? rsum_total : '0;
                end
                if (last_beat) flags <= final_flags;
            end
        end
    end
endmodule

// File: tb/tb_vector_exec_unit.sv
// Randomized self-checking bench for vector_exec_unit; two instances (4x1 and 8x2 lanes)
// share the stimulus bus, sel picks which one is driven and observed.
`timescale 1ns/1ps
module tb_vector_exec_unit;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset, start, use_scalar, ld_we, sel;
    logic [2:0]  op, ld_lane, rd_lane;
    logic [3:0]  vd, va, vb, ld_addr, rd_addr;
    logic [31:0] scalar_in, ld_data;
    logic        rdy_a, rdy_b, done_a, done_b;
    logic [3:0]  fl_a, fl_b;
    logic [31:0] rd_a, rd_b;
    logic        rdy_w, done_w;
    logic [3:0]  fl_w;
    logic [31:0] rd_w;

    assign rdy_w  = sel ? rdy_b  : rdy_a;
    assign done_w = sel ? done_b : done_a;
    assign fl_w   = sel ? fl_b   : fl_a;
    assign rd_w   = sel ? rd_b   : rd_a;

    vector_exec_unit #(.XLEN(32), .LANES(4), .NVREGS(16), .LPC(1)) u_dut4 (
        .clk(clk), .reset(reset), .start(start & ~sel), .ready(rdy_a), .op(op),
        .vd(vd), .va(va), .vb(vb), .use_scalar(use_scalar), .scalar_in(scalar_in),
        .done(done_a), .flags(fl_a), .ld_we(ld_we & ~sel), .ld_addr(ld_addr),
        .ld_lane(ld_lane[1:0]), .ld_data(ld_data), .rd_addr(rd_addr),
        .rd_lane(rd_lane[1:0]), .rd_data(rd_a));

    vector_exec_unit #(.XLEN(32), .LANES(8), .NVREGS(16), .LPC(2)) u_dut8 (
        .clk(clk), .reset(reset), .start(start & sel), .ready(rdy_b), .op(op),
        .vd(vd), .va(va), .vb(vb), .use_scalar(use_scalar), .scalar_in(scalar_in),
        .done(done_b), .flags(fl_b), .ld_we(ld_we & sel), .ld_addr(ld_addr),
        .ld_lane(ld_lane), .ld_data(ld_data), .rd_addr(rd_addr),
        .rd_lane(rd_lane), .rd_data(rd_b));

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [2][16][8];
    logic [3:0]  exp_flags;
    int          n0;

    function automatic int nl();
        return sel ? 8 : 4;
    endfunction

    function automatic int beats();
        return sel ? 4 : 4;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++)
                for (int l = 0; l < 8; l++)
                    mdl[d][r][l] = 32'h0;
    endtask

    // Whole-vector reference: every lane from the pre-op register contents.
    task automatic model_op(input logic [2:0] o, input logic [3:0] d_, a_, b_,
                            input bit us, input logic [31:0] sc);
        logic [31:0] r [8];
        logic [31:0] a, b, sum;
        bit n, nz, c, v;
        longint s;
        sum = 0; n = 0; nz = 0; c = 0; v = 0;
        for (int l = 0; l < nl(); l++) begin
            a = mdl[sel][a_][l];
            b = us ? sc : mdl[sel][b_][l];
            r[l] = 0;
            case (o)
                3'd0: begin
                    r[l] = a + b;
                    c |= (33'(a) + 33'(b)) > 33'h0_FFFF_FFFF;
                    s = longint'($signed(a)) + longint'($signed(b));
                    v |= (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                3'd1: begin
                    r[l] = a - b;
                    c |= (a >= b);
                    s = longint'($signed(a)) - longint'($signed(b));
                    v |= (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                3'd2: r[l] = a & b;
                3'd3: r[l] = a | b;
                3'd4: r[l] = a ^ b;
                3'd5: r[l] = (a < b) ? a : b;
                3'd6: r[l] = (a > b) ? a : b;
                default: sum += a;
            endcase
        end
        if (o == 3'd7) r[0] = sum;
        for (int l = 0; l < nl(); l++) begin
            n |= r[l][31];
            nz |= (r[l] != 0);
            mdl[sel][d_][l] = r[l];
        end
        exp_flags = {n, ~nz, c, v};
    endtask

    task automatic load(input logic [3:0] a, input logic [2:0] l, input logic [31:0] d);
        ld_addr = a; ld_lane = l; ld_data = d; ld_we = 1'b1;
        @(posedge clk); #1;
        ld_we = 1'b0;
        mdl[sel][a][l] = d;
    endtask

    task automatic begin_op(input logic [2:0] o, input logic [3:0] d_, a_, b_,
                            input bit us, input logic [31:0] sc, input bit ldw,
                            input logic [3:0] la, input logic [31:0] ldd, input bit poke);
        if (ldw) begin
            ld_addr = la; ld_lane = 0; ld_data = ldd; ld_we = 1'b1;
            mdl[sel][la][0] = ldd;
        end
        op = o; vd = d_; va = a_; vb = b_; use_scalar = us; scalar_in = sc; start = 1'b1;
        model_op(o, d_, a_, b_, us, sc);
        @(posedge clk); #1;
        start = 1'b0; ld_we = 1'b0;
        op = 3'($urandom); vd = 4'($urandom); va = 4'($urandom); vb = 4'($urandom);
        scalar_in = $urandom; use_scalar = 1'($urandom);
        check("busy_ready", 32'(rdy_w), 32'h0);
        n0 = 0;
        if (poke) begin
            start = 1'b1; ld_we = 1'b1; ld_addr = la; ld_lane = 1;
            ld_data = ~mdl[sel][la][1];
            @(posedge clk); #1;
            start = 1'b0; ld_we = 1'b0;
            n0 = 1;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = n0;
        while (done_w !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(beats()));
        check({tag, "_flags"}, 32'(fl_w), 32'(exp_flags));
    endtask

    task automatic finish_op(input string tag);
        wait_done(tag);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done_w), 32'h0);
        check({tag, "_idle_ready"}, 32'(rdy_w), 32'h1);
    endtask

    task automatic check_vec(input string tag, input logic [3:0] r);
        for (int l = 0; l < nl(); l++) begin
            rd_addr = r; rd_lane = 3'(l);
            #1;
            check(tag, rd_w, mdl[sel][r][l]);
        end
    endtask

    task automatic random_ops(input int count);
        logic [2:0] o;
        logic [3:0] d_, a_, b_;
        for (int i = 0; i < count; i++) begin
            load(4'($urandom), 3'($urandom_range(0, nl() - 1)), rval());
            load(4'($urandom), 3'($urandom_range(0, nl() - 1)), rval());
            o = 3'($urandom_range(0, 7));
            d_ = 4'($urandom); a_ = 4'($urandom); b_ = 4'($urandom);
            begin_op(o, d_, a_, b_, $urandom_range(0, 3) == 0, rval(), 1'b0, 4'h0, 32'h0, 1'b0);
            finish_op("rnd");
            check_vec("rnd_vec", d_);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 0; start = 0; ld_we = 0; sel = 0; op = 0; vd = 0; va = 0; vb = 0;
        use_scalar = 0; scalar_in = 0; ld_addr = 0; ld_lane = 0; ld_data = 0;
        rd_addr = 0; rd_lane = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy_a), 32'h1);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_flags", 32'(fl_a), 32'h0);
        check("rst_rd", rd_a, 32'h0);
        check("rst_ready8", 32'(rdy_b), 32'h1);
        reset = 1;
        @(posedge clk); #1;

        // 4 lanes x 1 per beat
        load(1, 0, 32'd1); load(1, 1, 32'd2); load(1, 2, 32'd3); load(1, 3, 32'hFFFF_FFFF);
        for (int l = 0; l < 4; l++) load(2, 3'(l), 32'd1);
        begin_op(3'd0, 3, 1, 2, 0, 0, 0, 0, 0, 0);
        finish_op("add");
        check("add_nzcv", 32'(fl_w), 32'b0010);
        check_vec("add_v3", 3);

        begin_op(3'd1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        finish_op("sub_alias");
        check("sub_nzcv", 32'(fl_w), 32'b0110);
        check_vec("sub_v1", 1);

        begin_op(3'd3, 5, 2, 0, 1, 32'h8000_0000, 0, 2, 0, 1);
        finish_op("orr_scalar");
        check("orr_nzcv", 32'(fl_w), 32'b1000);
        check_vec("orr_v5", 5);
        check_vec("busy_ld_ignored", 2);

        load(6, 0, 32'd5); load(6, 1, 32'd6); load(6, 2, 32'd7); load(6, 3, 32'd8);
        for (int l = 0; l < 4; l++) load(4, 3'(l), $urandom | 32'h1);
        begin_op(3'd7, 4, 6, 0, 0, 0, 0, 0, 0, 0);
        wait_done("rsum");
        begin_op(3'($urandom_range(0, 6)), 7, 3, 5, 0, 0, 0, 0, 0, 0);
        finish_op("b2b");
        check_vec("rsum_v4", 4);
        check_vec("b2b_v7", 7);

        begin_op(3'd0, 8, 9, 10, 0, 0, 1, 9, $urandom, 0);
        finish_op("ld_start");
        check_vec("ld_start_v8", 8);

        random_ops(24);

        // 8 lanes x 2 per beat
        sel = 1;
        for (int l = 0; l < 8; l++) begin
            load(1, 3'(l), rval());
            load(2, 3'(l), rval());
        end
        begin_op(3'd6, 3, 1, 2, 0, 0, 0, 0, 0, 0);
        finish_op("maxu8");
        check_vec("maxu8_v3", 3);
        random_ops(10);

        for (int l = 0; l < 8; l++) load(1, 3'(l), $urandom | 32'h1);
        begin_op(3'd6, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        #1;
        clear_model();
        check("abort_ready", 32'(rdy_b), 32'h1);
        check("abort_done", 32'(done_b), 32'h0);
        check("abort_flags", 32'(fl_b), 32'h0);
        check_vec("abort_v5", 5);
        check_vec("abort_v1", 1);
        @(posedge clk); #1;
        reset = 1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_idle_ready", 32'(rdy_b), 32'h1);
        check_vec("abort_after_v5", 5);
        sel = 0;
        check_vec("abort_a_v3", 3);
        sel = 1;
        random_ops(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
